// File: rtl/ifetch_tlb_pkg.sv
// Shared types for the instruction-fetch TLB: fault encoding, entry layout,
// page-walk request/result payloads and the fill-fault classifier.
package ifetch_tlb_pkg;

  localparam int unsigned SV32_VPN_W = 20;
  localparam int unsigned SV32_PPN_W = 22;
  localparam int unsigned SP_LO      = 10;
  localparam int unsigned PPN_HI_W   = SV32_PPN_W - SV32_VPN_W;

  typedef enum logic [1:0] {
    FAULT_NONE   = 2'd0,
    FAULT_PAGE   = 2'd1,
    FAULT_ACCESS = 2'd2
  } IFetchFault;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } tlb_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  superpage;
    logic [SV32_VPN_W-1:0] vpn;
    logic [SV32_VPN_W-1:0] ppn;
    IFetchFault            fault;
  } tlb_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [SV32_VPN_W-1:0] vpn;
  } pw_req_t;

  typedef struct packed {
    logic                  valid;
    logic [SV32_PPN_W-1:0] ppn;
    logic                  superpage;
    logic                  page_fault;
  } pw_res_t;

  // PPN bits above the fetchable physical range mean an access fault
  function automatic IFetchFault fill_fault(input logic page_fault,
                                            input logic [PPN_HI_W-1:0] ppn_hi);
    if (page_fault)      return FAULT_PAGE;
    if (ppn_hi != '0)    return FAULT_ACCESS;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/ifetch_tlb.sv
// Fully associative instruction TLB with zero-latency lookup and a single
// outstanding page-walk request; fills replace invalid entries first, then round-robin.
module ifetch_tlb
  import ifetch_tlb_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned VPN_W       = SV32_VPN_W,
  parameter int unsigned PPN_W       = SV32_PPN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_sv32en,
  input  logic             IN_flush,
  input  logic             IN_abort,
  input  logic             IN_lookupValid,
  input  logic [VPN_W-1:0] IN_vpn,
  output logic             OUT_hit,
  output logic [VPN_W-1:0] OUT_ppn,
  output logic [1:0]       OUT_fault,
  output logic             OUT_stall,
  output logic             OUT_pwValid,
  output logic [VPN_W-1:0] OUT_pwVPN,
  input  logic             IN_pwBusy,
  input  logic             IN_pwRqID,
  input  logic             IN_pwValid,
  input  logic [PPN_W-1:0] IN_pwPPN,
  input  logic             IN_pwSuperPage,
  input  logic             IN_pwPageFault
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  tlb_entry_t            entries [NUM_ENTRIES];
  tlb_state_e            state;
  pw_req_t               walk_req;
  pw_res_t               res;
  logic [IDX_W-1:0]      rr_ptr;
  logic [SV32_VPN_W-1:0] vpn_s;

  logic                  match;
  logic                  match_sp;
  logic [SV32_VPN_W-1:0] match_ppn;
  IFetchFault            match_fault;
  logic [IDX_W-1:0]      victim;
  logic                  use_rr;
  logic                  start;
  logic                  accept;
  logic                  fill;

  assign vpn_s = SV32_VPN_W'(IN_vpn);
  assign res   = '{valid:      IN_pwValid,
                   ppn:        SV32_PPN_W'(IN_pwPPN),
                   superpage:  IN_pwSuperPage,
                   page_fault: IN_pwPageFault};

  // Associative match; superpage entries compare only the upper VPN half
  always_comb begin
    match       = 1'b0;
    match_sp    = 1'b0;
    match_ppn   = '0;
    match_fault = FAULT_NONE;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (!match && entries[i].valid &&
          (entries[i].superpage ?
             (entries[i].vpn[SV32_VPN_W-1:SP_LO] == vpn_s[SV32_VPN_W-1:SP_LO]) :
             (entries[i].vpn == vpn_s))) begin
        match       = 1'b1;
        match_sp    = entries[i].superpage;
        match_ppn   = entries[i].ppn;
        match_fault = entries[i].fault;
      end
    end
  end

  always_comb begin
    OUT_hit   = 1'b1;
    OUT_ppn   = IN_vpn;
    OUT_fault = FAULT_NONE;
    if (IN_sv32en) begin
      OUT_hit   = match;
      OUT_fault = match_fault;
      OUT_ppn   = match_sp ?
                  VPN_W'({match_ppn[SV32_VPN_W-1:SP_LO], vpn_s[SP_LO-1:0]}) :
                  VPN_W'(match_ppn);
    end
  end

  assign OUT_stall   = IN_lookupValid && IN_sv32en && !OUT_hit;
  assign OUT_pwValid = walk_req.valid;
  assign OUT_pwVPN   = VPN_W'(walk_req.vpn);

  // Victim: lowest invalid entry, otherwise the round-robin slot
  always_comb begin
    victim = rr_ptr;
    use_rr = 1'b1;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (use_rr && !entries[i].valid) begin
        victim = IDX_W'(i);
        use_rr = 1'b0;
      end
    end
  end

  assign start  = (state == IDLE) && IN_lookupValid && IN_sv32en && !match &&
                  !IN_flush && !IN_abort;
  assign accept = (state == REQ) && IN_pwBusy && !IN_pwRqID;
  assign fill   = (state == WAIT) && res.valid && !IN_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      walk_req.valid <= 1'b0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) entries[i].valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ;
            walk_req <= '{valid: 1'b1, vpn: vpn_s};
          end
        end
        REQ: begin
          // Once the walker has taken the request its result must be consumed
          if (accept) begin
            state          <= IN_flush ? DRAIN : WAIT;
            walk_req.valid <= 1'b0;
          end else if (IN_abort || IN_flush) begin
            state          <= IDLE;
            walk_req.valid <= 1'b0;
          end
        end
        WAIT: begin
          if (res.valid)     state <= IDLE;
          else if (IN_flush) state <= DRAIN;
        end
        DRAIN: begin
          if (res.valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (IN_flush) begin
        for (int i = 0; i < int'(NUM_ENTRIES); i++) entries[i].valid <= 1'b0;
      end else if (fill) begin
        entries[victim] <= '{valid:     1'b1,
                             superpage: res.superpage,
                             vpn:       walk_req.vpn,
                             ppn:       res.ppn[SV32_VPN_W-1:0],
                             fault:     fill_fault(res.page_fault,
                                                   res.ppn[SV32_PPN_W-1:SV32_VPN_W])};
        if (use_rr) rr_ptr <= rr_ptr + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_tlb.sv
// Bench for ifetch_tlb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural translation model.
module tb_ifetch_tlb;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst, sv32en, flush, abort, lv;
  logic [19:0] vpn;
  logic        hit, stall, pwv_o;
  logic [19:0] ppn, pwvpn;
  logic [1:0]  fault;
  logic        busy, rqid, pwv_i, pwsp, pwpf;
  logic [21:0] pwppn;

  ifetch_tlb #(.NUM_ENTRIES(N), .VPN_W(20), .PPN_W(22)) dut (
    .clk(clk), .rst(rst), .IN_sv32en(sv32en), .IN_flush(flush), .IN_abort(abort),
    .IN_lookupValid(lv), .IN_vpn(vpn), .OUT_hit(hit), .OUT_ppn(ppn),
    .OUT_fault(fault), .OUT_stall(stall), .OUT_pwValid(pwv_o), .OUT_pwVPN(pwvpn),
    .IN_pwBusy(busy), .IN_pwRqID(rqid), .IN_pwValid(pwv_i), .IN_pwPPN(pwppn),
    .IN_pwSuperPage(pwsp), .IN_pwPageFault(pwpf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // requested stimulus for the next cycle
  logic        d_rst, d_en, d_lv, d_flush, d_abort;
  logic [19:0] d_vpn;

  // behavioural walker
  logic        rnd = 1'b0;
  logic        w_active = 1'b0;
  int          w_cnt = 0, w_seen = 0, acc_delay = 1, ret_lat = 0, walks = 0;
  logic [19:0] w_vpn;

  // reference translation cache
  logic        m_valid [N];
  logic        m_sp    [N];
  logic [19:0] m_vpn   [N];
  logic [19:0] m_ppn   [N];
  logic [1:0]  m_fault [N];
  int          m_rr = 0;
  logic        m_req_out = 1'b0, m_live = 1'b0, m_dead = 1'b0;
  logic [19:0] m_wvpn = '0;

  function automatic logic [21:0] res_ppn(input logic [19:0] v);
    if (v == 20'h00400)      return 22'h00080;
    if (v[19:10] == 10'h201) return 22'h00C00;
    return {(v[6:4] == 3'b101) ? 2'b01 : 2'b00, v ^ 20'hA5A50};
  endfunction

  function automatic logic res_sp(input logic [19:0] v);
    return (v[19:10] == 10'h201) || (v[19:18] == 2'b11);
  endfunction

  function automatic logic res_pf(input logic [19:0] v);
    return v[3:0] == 4'hF;
  endfunction

  function automatic logic [19:0] pick_vpn();
    logic [19:0] lo;
    lo = 20'($urandom_range(0, 1023));
    case ($urandom_range(0, 5))
      0:       return 20'h00400 + 20'($urandom_range(0, 3));
      1:       return 20'hC0000 | lo;
      2:       return 20'hC0400 | lo;
      3:       return 20'h03050;
      4:       return 20'h0300F;
      default: return 20'h7F000 + 20'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_lookup(input logic [19:0] v, output logic h, output logic [19:0] p,
                          output logic [1:0] f);
    h = 1'b0; p = '0; f = 2'd0;
    if (!sv32en) begin
      h = 1'b1; p = v;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && (m_sp[i] ? ((m_vpn[i] >> 10) == (v >> 10)) : (m_vpn[i] == v))) begin
        h = 1'b1;
        f = m_fault[i];
        p = m_sp[i] ? ((m_ppn[i] & 20'hFFC00) | (v & 20'h003FF)) : m_ppn[i];
      end
    end
  endtask

  task automatic m_fill();
    int slot;
    slot = -1;
    for (int i = 0; i < N; i++) if (slot < 0 && !m_valid[i]) slot = i;
    if (slot < 0) begin
      slot = m_rr;
      m_rr = (m_rr + 1) % N;
    end
    m_valid[slot] = 1'b1;
    m_vpn[slot]   = m_wvpn;
    m_sp[slot]    = pwsp;
    m_ppn[slot]   = pwppn[19:0];
    m_fault[slot] = pwpf ? 2'd1 : ((pwppn[21:20] != 2'b00) ? 2'd2 : 2'd0);
  endtask

  // Reference update for one rising edge using the inputs held this cycle
  task automatic model_edge();
    logic h; logic [19:0] p; logic [1:0] f;
    if (rst) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_rr = 0; m_req_out = 1'b0; m_live = 1'b0; m_dead = 1'b0;
    end else begin
      m_lookup(vpn, h, p, f);
      if (m_req_out) begin
        if (busy && !rqid) begin
          m_req_out = 1'b0;
          if (flush) m_dead = 1'b1; else m_live = 1'b1;
        end else if (abort || flush) m_req_out = 1'b0;
      end else if (m_live) begin
        if (pwv_i) begin
          m_live = 1'b0;
          if (!flush) m_fill();
        end else if (flush) begin
          m_live = 1'b0; m_dead = 1'b1;
        end
      end else if (m_dead) begin
        if (pwv_i) m_dead = 1'b0;
      end else if (lv && sv32en && !h && !flush && !abort) begin
        m_req_out = 1'b1; m_wvpn = vpn;
      end
      if (flush) for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end
  endtask

  task automatic apply();
    rst = d_rst; sv32en = d_en; lv = d_lv; vpn = d_vpn; flush = d_flush; abort = d_abort;
    pwv_i = 1'b0; busy = 1'b0; rqid = 1'b0; pwppn = '0; pwsp = 1'b0; pwpf = 1'b0;
    if (w_active) begin
      if (w_cnt == 0) begin
        pwv_i = 1'b1; pwppn = res_ppn(w_vpn); pwsp = res_sp(w_vpn); pwpf = res_pf(w_vpn);
        w_active = 1'b0;
      end else w_cnt--;
    end else if (pwv_o) begin
      w_seen++;
      if (w_seen >= acc_delay && !d_flush && !d_abort && !d_rst) begin
        busy = 1'b1; w_active = 1'b1; w_cnt = ret_lat; w_vpn = pwvpn; w_seen = 0; walks++;
        if (rnd) begin
          acc_delay = $urandom_range(1, 4);
          ret_lat   = $urandom_range(0, 5);
        end
      end else if (rnd && $urandom_range(0, 2) == 0) begin
        busy = 1'b1; rqid = 1'b1;
      end
    end else w_seen = 0;
  endtask

  task automatic compare_all();
    logic eh; logic [19:0] ep; logic [1:0] ef;
    m_lookup(vpn, eh, ep, ef);
    chk("hit", 32'(hit), 32'(eh));
    if (eh) begin
      chk("ppn", 32'(ppn), 32'(ep));
      chk("fault", 32'(fault), 32'(ef));
    end
    chk("stall", 32'(stall), 32'(lv && sv32en && !eh));
    chk("pw_valid", 32'(pwv_o), 32'(m_req_out));
    if (m_req_out) chk("pw_vpn", 32'(pwvpn), 32'(m_wvpn));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    apply();
    #1;
    if (chk_en) compare_all();
  endtask

  task automatic lookup_until_hit(input logic [19:0] v, input int max, output int pw_cycles);
    pw_cycles = 0;
    d_rst = 1'b0; d_en = 1'b1; d_lv = 1'b1; d_vpn = v; d_flush = 1'b0; d_abort = 1'b0;
    for (int c = 0; c < max; c++) begin
      tick();
      if (pwv_o) pw_cycles++;
      if (hit) break;
    end
    chk("walk_timeout", 32'(hit), 32'd1);
  endtask

  initial begin
    int pc, w0;
    logic saw;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_sp[i] = 1'b0; m_vpn[i] = '0; m_ppn[i] = '0; m_fault[i] = '0;
    end
    d_rst = 1'b1; d_en = 1'b1; d_lv = 1'b1; d_vpn = 20'h00400; d_flush = 1'b0; d_abort = 1'b0;
    apply();
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_pw_valid", 32'(pwv_o), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);

    // translation disabled: identity, no walk
    d_rst = 1'b0; d_en = 1'b0; d_vpn = 20'h12345;
    tick();
    chk("bare_hit", 32'(hit), 32'd1);
    chk("bare_ppn", 32'(ppn), 32'h12345);
    chk("bare_stall", 32'(stall), 32'd0);
    tick();
    chk("bare_no_walk", 32'(pwv_o), 32'd0);

    // basic miss, walker accepts on third request cycle
    acc_delay = 3; ret_lat = 2; w0 = walks;
    lookup_until_hit(20'h00400, 40, pc);
    chk("miss_pw_cycles", 32'(pc), 32'd3);
    chk("miss_walks", 32'(walks - w0), 32'd1);
    chk("miss_ppn", 32'(ppn), 32'h00080);
    chk("miss_fault", 32'(fault), 32'd0);
    tick();
    chk("refetch_no_walk", 32'(pwv_o), 32'd0);

    // superpage
    acc_delay = 1; ret_lat = 1;
    lookup_until_hit(20'h80400, 40, pc);
    chk("sp_ppn", 32'(ppn), 32'h00C00);
    d_vpn = 20'h807FF;
    tick();
    chk("sp_off_hit", 32'(hit), 32'd1);
    chk("sp_off_ppn", 32'(ppn), 32'h00FFF);

    // cached faults
    lookup_until_hit(20'h03050, 40, pc);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("acc_fault", 32'(fault), 32'd2);
      chk("acc_no_walk", 32'(pwv_o), 32'd0);
    end
    lookup_until_hit(20'h0300F, 40, pc);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pg_fault", 32'(fault), 32'd1);
      chk("pg_no_walk", 32'(pwv_o), 32'd0);
    end

    // flush while the walk is outstanding
    acc_delay = 1; ret_lat = 4;
    d_vpn = 20'h02000;
    for (int c = 0; c < 20 && !w_active; c++) tick();
    chk("flush_accept", 32'(w_active), 32'd1);
    d_flush = 1'b1;
    tick();
    d_flush = 1'b0;
    for (int c = 0; c < 20 && w_active; c++) tick();
    tick();
    chk("flush_discard", 32'(hit), 32'd0);
    saw = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (pwv_o) saw = 1'b1;
    end
    chk("flush_rewalk", 32'(saw), 32'd1);
    lookup_until_hit(20'h02000, 40, pc);

    // capacity: fifth fill evicts entry 0
    d_rst = 1'b1; d_lv = 1'b0;
    tick();
    d_rst = 1'b0;
    acc_delay = 1; ret_lat = 0;
    for (int i = 0; i < 5; i++) lookup_until_hit(20'h01000 + 20'(i), 40, pc);
    d_lv = 1'b0; d_vpn = 20'h01000;
    tick();
    chk("evict_first", 32'(hit), 32'd0);
    for (int i = 1; i < 5; i++) begin
      d_vpn = 20'h01000 + 20'(i);
      tick();
      chk("evict_keep", 32'(hit), 32'd1);
    end

    // randomized traffic
    rnd = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      d_rst   = ($urandom_range(0, 299) == 0);
      d_en    = ($urandom_range(0, 19) != 0);
      d_lv    = ($urandom_range(0, 3) != 0);
      if (!(stall && $urandom_range(0, 9) < 8)) d_vpn = pick_vpn();
      d_flush = ($urandom_range(0, 39) == 0);
      d_abort = ($urandom_range(0, 14) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
